lap_recorder: RTL and testbench

// - Sequences the stopwatch's lap feature: snapshots {hour,minute,second,m_sec} from the stopwatch on each lap press while running.
// - Stores snapshots in a DEPTH-entry circular buffer; lap presses while stopped browse stored entries.
// - Streams the selected entry to the LCD formatter over a valid/ready handshake.
// - Sits between the debounced lap/clear buttons, the stopwatch outputs and the LCD path.

---
 rtl/stopwatch_pkg.sv | 13 +
 rtl/lap_ram.sv | 19 +
 rtl/lap_recorder.sv | 88 ++++++++
 tb/tb_lap_recorder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared stopwatch field widths, lap limits and helpers
package stopwatch_pkg;
  localparam int HOUR_W = 6;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;
  localparam int MSEC_W = 7;
  localparam int LAP_W = HOUR_W + MIN_W + SEC_W + MSEC_W;
  localparam int LAP_NUM_W = 7;
  localparam logic [LAP_NUM_W-1:0] MAX_LAP_NUM = 7'd99;
  function automatic logic [LAP_NUM_W-1:0] sat_inc(input logic [LAP_NUM_W-1:0] n);
    return (n == MAX_LAP_NUM) ? n : n + 7'd1;
  endfunction
endpackage

// File: rtl/lap_ram.sv
// lap_ram: DEPTH x LAP_W lap store, one synchronous write port, one asynchronous read port
module lap_ram
  import stopwatch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clock,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [LAP_W-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [LAP_W-1:0] rd_data
);
  logic [LAP_W-1:0] mem [DEPTH];
  always_ff @(posedge clock)
    if (we) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/lap_recorder.sv
// lap_recorder: captures stopwatch laps into a circular buffer, browses them while stopped,
// and offers the selected lap to the LCD path over a valid/ready handshake
module lap_recorder
  import stopwatch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic                 lap,
  input  logic                 clear,
  input  logic [HOUR_W-1:0]    hour,
  input  logic [MIN_W-1:0]     minute,
  input  logic [SEC_W-1:0]     second,
  input  logic [MSEC_W-1:0]    m_sec,
  output logic [IDX_W:0]       lap_count,
  output logic [IDX_W-1:0]     view_idx,
  output logic                 overflow,
  output logic                 disp_valid,
  input  logic                 disp_ready,
  output logic [LAP_NUM_W-1:0] disp_lap_num,
  output logic [LAP_W-1:0]     disp_time
);
  localparam logic [IDX_W:0] FULL = DEPTH[IDX_W:0];
  logic lap_q, clear_q, primed;
  logic lap_rise, clear_rise, capture, browse, full;
  logic [IDX_W-1:0] wr_ptr, newest, oldest, age, browse_idx;
  logic [LAP_NUM_W-1:0] total;
  logic [LAP_W-1:0] rd_data;
  // primed masks the first edge after reset so a button held across release is not a press
  assign lap_rise = lap & ~lap_q & primed;
  assign clear_rise = clear & ~clear_q & primed;
  assign full = lap_count == FULL;
  assign capture = lap_rise & run & ~clear_rise;
  assign browse = lap_rise & ~run & ~clear_rise & (lap_count != '0);
  assign newest = wr_ptr - 1'b1;
  assign oldest = full ? wr_ptr : '0;
  assign browse_idx = (view_idx == oldest) ? newest : view_idx - 1'b1;
  assign age = newest - view_idx;
  assign disp_lap_num = (lap_count != '0) ? total - 7'(age) : '0;
  assign disp_time = (lap_count != '0) ? rd_data : '0;
  lap_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clock  (clock),
    .we     (capture),
    .wr_addr(wr_ptr),
    .wr_data({hour, minute, second, m_sec}),
    .rd_addr(view_idx),
    .rd_data(rd_data)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      lap_q      <= 1'b0;
      clear_q    <= 1'b0;
      primed     <= 1'b0;
      lap_count  <= '0;
      wr_ptr     <= '0;
      view_idx   <= '0;
      overflow   <= 1'b0;
      total      <= '0;
      disp_valid <= 1'b0;
    end else begin
      lap_q   <= lap;
      clear_q <= clear;
      primed  <= 1'b1;
      if (clear_rise) begin
        lap_count  <= '0;
        wr_ptr     <= '0;
        view_idx   <= '0;
        overflow   <= 1'b0;
        total      <= '0;
        disp_valid <= 1'b0;
      end else if (capture) begin
        wr_ptr     <= wr_ptr + 1'b1;
        view_idx   <= wr_ptr;
        lap_count  <= full ? lap_count : lap_count + 1'b1;
        overflow   <= overflow | full;
        total      <= sat_inc(total);
        disp_valid <= 1'b1;
      end else if (browse) begin
        view_idx   <= browse_idx;
        disp_valid <= 1'b1;
      end else if (disp_valid & disp_ready) begin
        disp_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_lap_recorder.sv
// tb_lap_recorder: scenario and randomized checks of lap_recorder against a queue-based lap model
module tb_lap_recorder;
  import stopwatch_pkg::*;
  logic clock = 1'b0, reset_n = 1'b0, run = 1'b0, lap = 1'b0, clear = 1'b0, disp_ready = 1'b0;
  logic [5:0] hour = '0, minute = '0, second = '0;
  logic [6:0] m_sec = '0;
  logic [3:0] lap_count;
  logic [2:0] view_idx;
  logic overflow, disp_valid;
  logic [6:0] disp_lap_num;
  logic [24:0] disp_time;
  int vectors = 0, errors = 0;
  typedef struct { int num; int slot; logic [24:0] t; } entry_t;
  entry_t q[$];
  int m_view, m_total, m_n;
  bit m_ovf, m_valid, m_lapq, m_clrq, m_primed;

  always #5 clock = ~clock;

  lap_recorder #(.DEPTH(8), .IDX_W(3)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .lap(lap), .clear(clear),
    .hour(hour), .minute(minute), .second(second), .m_sec(m_sec),
    .lap_count(lap_count), .view_idx(view_idx), .overflow(overflow),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_lap_num(disp_lap_num), .disp_time(disp_time)
  );

  function automatic void model_reset();
    q.delete();
    m_view = 0; m_total = 0; m_n = 0;
    m_ovf = 0; m_valid = 0; m_lapq = 0; m_clrq = 0; m_primed = 0;
  endfunction

  function automatic void model_edge();
    bit lr, cr;
    lr = lap && !m_lapq && m_primed;
    cr = clear && !m_clrq && m_primed;
    if (cr) begin
      q.delete(); m_view = 0; m_ovf = 0; m_total = 0; m_n = 0; m_valid = 0;
    end else if (lr && run) begin
      m_total = (m_total < 99) ? m_total + 1 : 99;
      q.push_back('{num: m_total, slot: m_n % 8, t: {hour, minute, second, m_sec}});
      m_n++;
      if (q.size() > 8) begin
        void'(q.pop_front());
        m_ovf = 1;
      end
      m_view = q.size() - 1;
      m_valid = 1;
    end else if (lr && !run && q.size() > 0) begin
      m_view = (m_view == 0) ? q.size() - 1 : m_view - 1;
      m_valid = 1;
    end else if (m_valid && disp_ready) begin
      m_valid = 0;
    end
    m_lapq = lap; m_clrq = clear; m_primed = 1;
  endfunction

  function automatic int exp_num();
    return (q.size() > 0) ? q[m_view].num : 0;
  endfunction

  function automatic logic [24:0] exp_time();
    return (q.size() > 0) ? q[m_view].t : 25'd0;
  endfunction

  task automatic tick();
    @(posedge clock);
    if (reset_n) model_edge(); else model_reset();
    #1;
  endtask

  task automatic press();
    lap = 1'b1; tick();
    lap = 1'b0; tick();
  endtask

  task automatic do_clear();
    clear = 1'b1; tick();
    clear = 1'b0; tick();
  endtask

  task automatic set_time(input int h, input int mi, input int s, input int ms);
    hour = 6'(h); minute = 6'(mi); second = 6'(s); m_sec = 7'(ms);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    vectors += 6;
    if (lap_count !== 4'd0) begin errors++; $display("FAIL reset lap_count: got %0d want 0", lap_count); end
    if (view_idx !== 3'd0) begin errors++; $display("FAIL reset view_idx: got %0d want 0", view_idx); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b want 0", overflow); end
    if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset disp_valid: got %b want 0", disp_valid); end
    if (disp_lap_num !== 7'd0) begin errors++; $display("FAIL reset disp_lap_num: got %0d want 0", disp_lap_num); end
    if (disp_time !== 25'd0) begin errors++; $display("FAIL reset disp_time: got %h want 0", disp_time); end
    repeat (2) tick();
  endtask

  task automatic test_first_lap();
    logic [24:0] want;
    want = {6'd0, 6'd0, 6'd1, 7'd23};
    run = 1'b1; disp_ready = 1'b0;
    set_time(0, 0, 1, 23);
    lap = 1'b1;
    #1;
    vectors++;
    if (disp_valid !== 1'b0) begin errors++; $display("FAIL first_lap early_valid: got %b want 0", disp_valid); end
    tick();
    lap = 1'b0;
    set_time(3, 4, 5, 6);
    vectors += 4;
    if (lap_count !== 4'd1) begin errors++; $display("FAIL first_lap count: got %0d want 1", lap_count); end
    if (disp_valid !== 1'b1) begin errors++; $display("FAIL first_lap valid: got %b want 1", disp_valid); end
    if (disp_lap_num !== 7'd1) begin errors++; $display("FAIL first_lap num: got %0d want 1", disp_lap_num); end
    if (disp_time !== want) begin errors++; $display("FAIL first_lap time: got %h want %h", disp_time, want); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (disp_valid !== 1'b1 || disp_time !== want) begin
        errors++; $display("FAIL first_lap hold: got valid %b time %h want 1 %h", disp_valid, disp_time, want);
      end
    end
    disp_ready = 1'b1;
    tick();
    disp_ready = 1'b0;
    vectors++;
    if (disp_valid !== 1'b0) begin errors++; $display("FAIL first_lap xfer: got %b want 0", disp_valid); end
  endtask

  task automatic test_overflow();
    do_clear();
    run = 1'b1; disp_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      set_time(0, i, i + 10, i * 3);
      press();
    end
    vectors += 5;
    if (lap_count !== 4'd8) begin errors++; $display("FAIL overflow count: got %0d want 8", lap_count); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow flag: got %b want 1", overflow); end
    if (disp_lap_num !== 7'd9) begin errors++; $display("FAIL overflow num: got %0d want 9", disp_lap_num); end
    if (view_idx !== 3'd0) begin errors++; $display("FAIL overflow slot: got %0d want 0", view_idx); end
    if (disp_time !== {6'd0, 6'd9, 6'd19, 7'd27}) begin errors++; $display("FAIL overflow time: got %h want %h", disp_time, {6'd0, 6'd9, 6'd19, 7'd27}); end
    run = 1'b0;
    repeat (7) press();
    vectors += 2;
    if (disp_lap_num !== 7'd2) begin errors++; $display("FAIL overflow oldest: got %0d want 2", disp_lap_num); end
    if (disp_time !== {6'd0, 6'd2, 6'd12, 7'd6}) begin errors++; $display("FAIL overflow oldest_time: got %h want %h", disp_time, {6'd0, 6'd2, 6'd12, 7'd6}); end
    disp_ready = 1'b0;
  endtask

  task automatic test_browse();
    int want [4] = '{2, 1, 3, 2};
    do_clear();
    run = 1'b1; disp_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      set_time(1, 2, i, 40 + i);
      press();
    end
    run = 1'b0; disp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      lap = 1'b1; tick();
      vectors += 3;
      if (disp_valid !== 1'b1) begin errors++; $display("FAIL browse valid%0d: got %b want 1", k, disp_valid); end
      if (disp_lap_num !== 7'(want[k])) begin errors++; $display("FAIL browse num%0d: got %0d want %0d", k, disp_lap_num, want[k]); end
      if (disp_time !== exp_time()) begin errors++; $display("FAIL browse time%0d: got %h want %h", k, disp_time, exp_time()); end
      lap = 1'b0; disp_ready = 1'b1; tick();
      disp_ready = 1'b0;
      vectors++;
      if (disp_valid !== 1'b0) begin errors++; $display("FAIL browse single%0d: got %b want 0", k, disp_valid); end
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    run = 1'b1; disp_ready = 1'b0;
    set_time(2, 0, 0, 1); press();
    set_time(2, 0, 0, 2); press();
    vectors += 3;
    if (disp_valid !== 1'b1) begin errors++; $display("FAIL b2b valid: got %b want 1", disp_valid); end
    if (disp_lap_num !== 7'd2) begin errors++; $display("FAIL b2b num: got %0d want 2", disp_lap_num); end
    if (disp_time !== {6'd2, 6'd0, 6'd0, 7'd2}) begin errors++; $display("FAIL b2b time: got %h want %h", disp_time, {6'd2, 6'd0, 6'd0, 7'd2}); end
    disp_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (disp_valid !== 1'b0) begin errors++; $display("FAIL b2b duplicate%0d: got %b want 0", i, disp_valid); end
      tick();
    end
    disp_ready = 1'b0;
  endtask

  task automatic test_clear_lap();
    do_clear();
    run = 1'b1; disp_ready = 1'b0;
    for (int i = 0; i < 9; i++) press();
    clear = 1'b1; lap = 1'b1; tick();
    clear = 1'b0; lap = 1'b0;
    vectors += 4;
    if (lap_count !== 4'd0) begin errors++; $display("FAIL clear_lap count: got %0d want 0", lap_count); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL clear_lap overflow: got %b want 0", overflow); end
    if (disp_valid !== 1'b0) begin errors++; $display("FAIL clear_lap valid: got %b want 0", disp_valid); end
    if (view_idx !== 3'd0) begin errors++; $display("FAIL clear_lap view: got %0d want 0", view_idx); end
    tick();
    vectors++;
    if (lap_count !== 4'd0) begin errors++; $display("FAIL clear_lap stored: got %0d want 0", lap_count); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      run = ($urandom_range(3) != 0);
      lap = ($urandom_range(2) == 0);
      clear = ($urandom_range(80) == 0) || (m_total >= 90);
      disp_ready = $urandom_range(1);
      set_time($urandom_range(59), $urandom_range(59), $urandom_range(59), $urandom_range(99));
      tick();
      vectors += 4;
      if (lap_count !== 4'(q.size())) begin errors++; $display("FAIL rand count @%0d: got %0d want %0d", c, lap_count, q.size()); end
      if (overflow !== m_ovf) begin errors++; $display("FAIL rand overflow @%0d: got %b want %b", c, overflow, m_ovf); end
      if (disp_valid !== m_valid) begin errors++; $display("FAIL rand valid @%0d: got %b want %b", c, disp_valid, m_valid); end
      if (disp_lap_num !== 7'(exp_num())) begin errors++; $display("FAIL rand num @%0d: got %0d want %0d", c, disp_lap_num, exp_num()); end
      if (q.size() > 0) begin
        vectors += 2;
        if (view_idx !== 3'(q[m_view].slot)) begin errors++; $display("FAIL rand view @%0d: got %0d want %0d", c, view_idx, q[m_view].slot); end
        if (disp_time !== exp_time()) begin errors++; $display("FAIL rand time @%0d: got %h want %h", c, disp_time, exp_time()); end
      end
    end
    lap = 1'b0; clear = 1'b0; disp_ready = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    do_clear();
    run = 1'b1; disp_ready = 1'b1;
    for (int i = 0; i < 100; i++) press();
    vectors += 3;
    if (disp_lap_num !== 7'd99) begin errors++; $display("FAIL sat num: got %0d want 99", disp_lap_num); end
    if (lap_count !== 4'd8) begin errors++; $display("FAIL sat count: got %0d want 8", lap_count); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL sat overflow: got %b want 1", overflow); end
    disp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_clear();
    run = 1'b1; disp_ready = 1'b0;
    set_time(5, 5, 5, 5);
    press();
    vectors++;
    if (disp_valid !== 1'b1) begin errors++; $display("FAIL rst_mid pre_valid: got %b want 1", disp_valid); end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    vectors += 4;
    if (disp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid valid: got %b want 0", disp_valid); end
    if (lap_count !== 4'd0) begin errors++; $display("FAIL rst_mid count: got %0d want 0", lap_count); end
    if (disp_lap_num !== 7'd0) begin errors++; $display("FAIL rst_mid num: got %0d want 0", disp_lap_num); end
    if (disp_time !== 25'd0) begin errors++; $display("FAIL rst_mid time: got %h want 0", disp_time); end
    lap = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    vectors += 2;
    if (lap_count !== 4'd0) begin errors++; $display("FAIL rst_mid held_lap count: got %0d want 0", lap_count); end
    if (disp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid held_lap valid: got %b want 0", disp_valid); end
    lap = 1'b0;
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_lap();
    test_overflow();
    test_browse();
    test_back_to_back();
    test_clear_lap();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
